// File: rtl/timer_sequencer_pkg.sv
// Shared definitions for the timer sequencer: FSM state type and its encoding.
package timer_sequencer_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    LOAD = S_LOAD,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_e;

endpackage

// File: rtl/timer_sequencer_counter.sv
// N-bit up/down counter with synchronous load; load wins over enable.
// All updates on the falling edge of clk.
module updown_load_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [N-1:0] load_val_i,
  input  logic         en_i,
  input  logic         up_i,
  output logic [N-1:0] count_o
);

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;

  // Next count: load, step in the selected direction, or hold.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = up_i ? (count_q + 1'b1) : (count_q - 1'b1);
    end
  end

  // Count register.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/timer_sequencer.sv
// Timer sequencer: one-shot or auto-reload up/down timer with a registered
// terminal pulse. State changes on the falling edge of clk.
// Optional feature macro: TIMER_SEQUENCER_PRESCALER_EN adds a presc+1 advance
// divider; without it the counter advances on every RUN cycle.
//
// state | meaning
// IDLE  | waiting for start, count holds
// LOAD  | one cycle: latch config, preset count to its initial value
// RUN   | counting; terminal either reloads (periodic) or finishes
// DONE  | one cycle after a one-shot terminal, busy low, then IDLE
module timer_sequencer
  import timer_sequencer_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic          periodic,
  input  logic          dir_up,
  input  logic [N-1:0]  period,
  input  logic [PW-1:0] presc,
  output logic [N-1:0]  count,
  output logic          busy,
  output logic          tick
);

  state_e       state_q, state_d;
  logic [N-1:0] period_q;
  logic         dir_up_q;
  logic         periodic_q;
  logic         tick_q, tick_d;
  logic         latch_cfg;
  logic         ctr_load;
  logic         ctr_en;
  logic [N-1:0] ctr_load_val;
  logic         adv;
  logic         term;

  assign term = dir_up_q ? (count == period_q) : (count == '0);

`ifdef TIMER_SEQUENCER_PRESCALER_EN
  logic [PW-1:0] presc_q;
  logic [PW-1:0] psc_q, psc_d;

  assign adv = (psc_q == presc_q);

  // Divider restarts in LOAD and after every advance, which includes reload.
  always_comb begin
    psc_d = psc_q;
    if (state_q == LOAD) begin
      psc_d = '0;
    end else if (state_q == RUN) begin
      psc_d = adv ? '0 : (psc_q + 1'b1);
    end
  end

  // Prescaler count and its latched divide value.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc_q   <= '0;
      presc_q <= '0;
    end else begin
      psc_q <= psc_d;
      if (latch_cfg) begin
        presc_q <= presc;
      end
    end
  end
`else
  logic unused_presc;
  assign unused_presc = ^presc;
  assign adv = 1'b1;
`endif

  // Next state, counter controls and terminal pulse; stop beats terminal.
  always_comb begin
    state_d      = state_q;
    latch_cfg    = 1'b0;
    ctr_load     = 1'b0;
    ctr_en       = 1'b0;
    ctr_load_val = dir_up_q ? '0 : period_q;
    tick_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          latch_cfg    = 1'b1;
          ctr_load     = 1'b1;
          ctr_load_val = dir_up ? '0 : period;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (adv) begin
          if (term) begin
            tick_d = 1'b1;
            if (periodic_q) begin
              ctr_load = 1'b1;
            end else begin
              state_d = DONE;
            end
          end else begin
            ctr_en = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, tick and latched configuration registers.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      tick_q     <= 1'b0;
      period_q   <= '0;
      dir_up_q   <= 1'b0;
      periodic_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      if (latch_cfg) begin
        period_q   <= period;
        dir_up_q   <= dir_up;
        periodic_q <= periodic;
      end
    end
  end

  updown_load_counter #(
    .N(N)
  ) u_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (ctr_load),
    .load_val_i(ctr_load_val),
    .en_i      (ctr_en),
    .up_i      (dir_up_q),
    .count_o   (count)
  );

  assign busy = (state_q == LOAD) || (state_q == RUN);
  assign tick = tick_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer; expected values are hand-derived.
// Active edge is the falling edge; outputs are sampled 1 time unit after it.
module tb_timer_sequencer;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       stop;
  logic       periodic;
  logic       dir_up;
  logic [3:0] period;
  logic [3:0] presc;
  logic [3:0] count;
  logic       busy;
  logic       tick;

  int n_assert;
  int n_fail;

  timer_sequencer #(
    .N (4),
    .PW(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .stop    (stop),
    .periodic(periodic),
    .dir_up  (dir_up),
    .period  (period),
    .presc   (presc),
    .count   (count),
    .busy    (busy),
    .tick    (tick)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    periodic = 1'b0;
    dir_up   = 1'b0;
    period   = 4'd0;
    presc    = 4'd0;

    #12;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    reset_n = 1'b1;

    // One-shot down, period 3
    period = 4'd3; dir_up = 1'b0; periodic = 1'b0; start = 1'b1;
    step();
    chk("os_e0_busy", busy, 1);
    chk("os_e0_count", count, 0);
    start = 1'b0;
    step(); chk("os_e1_count", count, 3); chk("os_e1_busy", busy, 1);
    step(); chk("os_e2_count", count, 2);
    step(); chk("os_e3_count", count, 1);
    step(); chk("os_e4_count", count, 0); chk("os_e4_tick", tick, 0);
    step(); chk("os_e5_tick", tick, 1); chk("os_e5_count", count, 0); chk("os_e5_busy", busy, 0);
    step(); chk("os_e6_tick", tick, 0); chk("os_e6_busy", busy, 0); chk("os_e6_count", count, 0);

    // Periodic up, period 15; mid-run config changes and start are ignored
    period = 4'd15; dir_up = 1'b1; periodic = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      step();
      chk("per_count", count, (e - 1) % 16);
      chk("per_tick", tick, (e >= 17 && ((e - 1) % 16) == 0) ? 1 : 0);
      chk("per_busy", busy, 1);
      if (e == 5) begin
        period = 4'd4; dir_up = 1'b0; start = 1'b1;
      end
      if (e == 6) start = 1'b0;
    end
    stop = 1'b1;
    step();
    chk("per_stop_busy", busy, 0);
    chk("per_stop_tick", tick, 0);
    chk("per_stop_count", count, 7);
    stop = 1'b0;

    // Stop in RUN at count 5, then start+stop in IDLE, then stop in LOAD
    period = 4'd10; dir_up = 1'b1; periodic = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    steps(6);
    chk("stp_pre_count", count, 5);
    stop = 1'b1;
    step();
    chk("stp_busy", busy, 0); chk("stp_count", count, 5); chk("stp_tick", tick, 0);
    start = 1'b1;
    step(); chk("ss_busy_a", busy, 0);
    step(); chk("ss_busy_b", busy, 0); chk("ss_count", count, 5);
    stop = 1'b0;
    step(); chk("ld_busy", busy, 1);
    start = 1'b0; stop = 1'b1;
    step(); chk("ldstp_busy", busy, 0); chk("ldstp_count", count, 5);
    stop = 1'b0;

    // Stop on the terminal edge suppresses tick
    period = 4'd2; dir_up = 1'b0; periodic = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); chk("tstp_e1", count, 2);
    step(); chk("tstp_e2", count, 1);
    step(); chk("tstp_e3", count, 0);
    stop = 1'b1;
    step(); chk("tstp_tick", tick, 0); chk("tstp_busy", busy, 0); chk("tstp_count", count, 0);
    stop = 1'b0;
    step(); chk("tstp_tick2", tick, 0);

    // Periodic, period 0: tick every cycle from edge 2; async reset clears tick
    period = 4'd0; dir_up = 1'b0; periodic = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step(); chk("p0_e1_tick", tick, 0); chk("p0_e1_count", count, 0);
    for (int e = 2; e <= 6; e++) begin
      step();
      chk("p0_tick", tick, 1);
      chk("p0_count", count, 0);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("ar0_tick", tick, 0); chk("ar0_busy", busy, 0); chk("ar0_count", count, 0);
    #3 reset_n = 1'b1;

    // First start after reset is accepted; reset mid-run clears count
    period = 4'd7; dir_up = 1'b0; periodic = 1'b1; start = 1'b1;
    step(); chk("ar_start_busy", busy, 1);
    start = 1'b0;
    step(); chk("ar_e1_count", count, 7);
    step(); chk("ar_e2_count", count, 6);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_count", count, 0); chk("ar_busy", busy, 0); chk("ar_tick", tick, 0);
    #3 reset_n = 1'b1;
    period = 4'd9; periodic = 1'b0; start = 1'b1;
    step(); chk("ar2_busy", busy, 1);
    start = 1'b0;
    step(); chk("ar2_count", count, 9);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Prescaler: presc 2, period 1, down, one-shot
    period = 4'd1; dir_up = 1'b0; periodic = 1'b0; presc = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
`ifdef TIMER_SEQUENCER_PRESCALER_EN
    step(); chk("psc_e1", count, 1);
    step(); chk("psc_e2", count, 1);
    step(); chk("psc_e3", count, 1);
    step(); chk("psc_e4", count, 0);
    step(); chk("psc_e5", count, 0); chk("psc_e5_tick", tick, 0);
    step(); chk("psc_e6", count, 0); chk("psc_e6_tick", tick, 0);
    step(); chk("psc_e7_tick", tick, 1); chk("psc_e7_busy", busy, 0);
`else
    step(); chk("npsc_e1", count, 1);
    step(); chk("npsc_e2", count, 0); chk("npsc_e2_tick", tick, 0);
    step(); chk("npsc_e3_tick", tick, 1); chk("npsc_e3_busy", busy, 0);
`endif
    step(); chk("psc_end_tick", tick, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
